// File: rtl/tlb_srch_rd_engine_if.sv
// Handshake bundles for the TLB search/read engine: the commit-stage request
// channel and the synchronous TLB array read port.
interface tlb_req_if #(parameter int IDX_W = 6);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [IDX_W-1:0] req_idx;

  modport master (output req_valid, req_op, req_idx, input req_ready);
  modport slave  (input req_valid, req_op, req_idx, output req_ready);
endinterface

interface tlb_arr_if #(parameter int IDX_W = 6);
  logic             tlb_rd_en;
  logic [IDX_W-1:0] tlb_rd_addr;
  logic             tlb_rd_e;
  logic             tlb_rd_g;
  logic [5:0]       tlb_rd_ps;
  logic [18:0]      tlb_rd_vppn;
  logic [9:0]       tlb_rd_asid;

  modport master (output tlb_rd_en, tlb_rd_addr,
                  input tlb_rd_e, tlb_rd_g, tlb_rd_ps, tlb_rd_vppn, tlb_rd_asid);
  modport slave  (input tlb_rd_en, tlb_rd_addr,
                  output tlb_rd_e, tlb_rd_g, tlb_rd_ps, tlb_rd_vppn, tlb_rd_asid);
endinterface

// File: rtl/tlb_srch_rd_engine.sv
// TLBSRCH / TLBRD engine scanning the TLB through one synchronous read port.
// Optional hit/miss statistics counters: define TLB_SRCH_STATS_EN.
module tlb_srch_rd_engine #(
  parameter int TLB_NUM = 64,
  parameter int IDX_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  tlb_req_if.slave    req,
  tlb_arr_if.master   arr,
  input  logic [18:0] csr_vppn,
  input  logic [9:0]  csr_asid,
  output logic        TLBSRCH,
  output logic        TLBSRCH_hit,
  output logic [5:0]  TLBSRCH_hit_idx,
  output logic        TLBRD_en,
  output logic [5:0]  TLB_PS,
  output logic        TLB_E
`ifdef TLB_SRCH_STATS_EN
  ,
  output logic [31:0] srch_hit_cnt,
  output logic [31:0] srch_miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, LAST, RESP} state_t;

  state_t           state_r;
  logic             op_r;
  logic             oor_r;
  logic [18:0]      vppn_r;
  logic [9:0]       asid_r;
  logic             rd_en_r;
  logic [IDX_W-1:0] rd_addr_r;
  logic             cmp_vld_r;
  logic [IDX_W-1:0] cmp_idx_r;
  logic             vppn_eq_s;
  logic             match_s;
  logic             in_range_s;
  logic             last_addr_s;

  // Entry match against the latched search key; 2MB pages compare only VPPN[18:9].
  always_comb begin
    vppn_eq_s = 1'b0;
    if (arr.tlb_rd_ps == 6'd21) begin
      vppn_eq_s = (arr.tlb_rd_vppn[18:9] == vppn_r[18:9]);
    end else begin
      vppn_eq_s = (arr.tlb_rd_vppn == vppn_r);
    end
    match_s = arr.tlb_rd_e && (arr.tlb_rd_g || (arr.tlb_rd_asid == asid_r)) && vppn_eq_s;
  end

  assign in_range_s  = ({1'b0, req.req_idx} < (IDX_W+1)'(TLB_NUM));
  assign last_addr_s = (rd_addr_r == IDX_W'(TLB_NUM - 1));

  // Flush must kill the read strobe and the accept in the same cycle it is seen.
  assign req.req_ready   = (state_r == IDLE) && !flush;
  assign arr.tlb_rd_en   = rd_en_r && !flush;
  assign arr.tlb_rd_addr = rd_addr_r;

  // Engine FSM with registered read strobe and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      op_r            <= 1'b0;
      oor_r           <= 1'b0;
      vppn_r          <= 19'd0;
      asid_r          <= 10'd0;
      rd_en_r         <= 1'b0;
      rd_addr_r       <= '0;
      cmp_vld_r       <= 1'b0;
      cmp_idx_r       <= '0;
      TLBSRCH         <= 1'b0;
      TLBSRCH_hit     <= 1'b0;
      TLBSRCH_hit_idx <= 6'd0;
      TLBRD_en        <= 1'b0;
      TLB_PS          <= 6'd0;
      TLB_E           <= 1'b0;
    end else begin
      TLBSRCH   <= 1'b0;
      TLBRD_en  <= 1'b0;
      cmp_vld_r <= rd_en_r;
      cmp_idx_r <= rd_addr_r;
      if (flush) begin
        state_r   <= IDLE;
        rd_en_r   <= 1'b0;
        cmp_vld_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (req.req_valid) begin
              op_r   <= req.req_op;
              vppn_r <= csr_vppn;
              asid_r <= csr_asid;
              if (!req.req_op) begin
                rd_en_r   <= 1'b1;
                rd_addr_r <= '0;
                state_r   <= SCAN;
              end else begin
                oor_r   <= !in_range_s;
                rd_en_r <= in_range_s;
                if (in_range_s) begin
                  rd_addr_r <= req.req_idx;
                end
                state_r <= LAST;
              end
            end
          end
          SCAN: begin
            if (cmp_vld_r && match_s) begin
              rd_en_r         <= 1'b0;
              state_r         <= RESP;
              TLBSRCH         <= 1'b1;
              TLBSRCH_hit     <= 1'b1;
              TLBSRCH_hit_idx <= 6'(cmp_idx_r);
            end else if (last_addr_s) begin
              rd_en_r <= 1'b0;
              state_r <= LAST;
            end else begin
              rd_addr_r <= rd_addr_r + IDX_W'(1);
            end
          end
          LAST: begin
            rd_en_r <= 1'b0;
            if (op_r) begin
              if (oor_r) begin
                TLBRD_en <= 1'b1;
                TLB_PS   <= 6'd0;
                TLB_E    <= 1'b0;
                state_r  <= RESP;
              end else if (cmp_vld_r) begin
                TLBRD_en <= 1'b1;
                TLB_PS   <= arr.tlb_rd_ps;
                TLB_E    <= arr.tlb_rd_e;
                state_r  <= RESP;
              end
            end else if (cmp_vld_r) begin
              TLBSRCH <= 1'b1;
              state_r <= RESP;
              if (match_s) begin
                TLBSRCH_hit     <= 1'b1;
                TLBSRCH_hit_idx <= 6'(cmp_idx_r);
              end else begin
                TLBSRCH_hit <= 1'b0;
              end
            end
          end
          RESP:    state_r <= IDLE;
          default: state_r <= IDLE;
        endcase
      end
    end
  end

`ifdef TLB_SRCH_STATS_EN
  // Saturating hit/miss counters, stepped on each search-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_hit_cnt  <= 32'd0;
      srch_miss_cnt <= 32'd0;
    end else if (TLBSRCH) begin
      if (TLBSRCH_hit) begin
        if (srch_hit_cnt != 32'hFFFF_FFFF) srch_hit_cnt <= srch_hit_cnt + 32'd1;
      end else begin
        if (srch_miss_cnt != 32'hFFFF_FFFF) srch_miss_cnt <= srch_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlb_srch_rd_engine.sv
// Directed bench for tlb_srch_rd_engine with a registered TLB array model.
module tb_tlb_srch_rd_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [18:0] csr_vppn = 19'd0;
  logic [9:0]  csr_asid = 10'd0;
  logic        TLBSRCH, TLBSRCH_hit, TLBRD_en, TLB_E;
  logic [5:0]  TLBSRCH_hit_idx, TLB_PS;
`ifdef TLB_SRCH_STATS_EN
  logic [31:0] srch_hit_cnt, srch_miss_cnt;
`endif

  tlb_req_if #(.IDX_W(6)) rq ();
  tlb_arr_if #(.IDX_W(6)) ar ();

  tlb_srch_rd_engine #(.TLB_NUM(64), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(rq.slave), .arr(ar.master),
    .csr_vppn(csr_vppn), .csr_asid(csr_asid),
    .TLBSRCH(TLBSRCH), .TLBSRCH_hit(TLBSRCH_hit), .TLBSRCH_hit_idx(TLBSRCH_hit_idx),
    .TLBRD_en(TLBRD_en), .TLB_PS(TLB_PS), .TLB_E(TLB_E)
`ifdef TLB_SRCH_STATS_EN
    , .srch_hit_cnt(srch_hit_cnt), .srch_miss_cnt(srch_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic        m_e [64];
  logic        m_g [64];
  logic [5:0]  m_ps [64];
  logic [18:0] m_vppn [64];
  logic [9:0]  m_asid [64];

  // Synchronous-read array model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ar.tlb_rd_en) begin
      ar.tlb_rd_e    <= m_e[ar.tlb_rd_addr];
      ar.tlb_rd_g    <= m_g[ar.tlb_rd_addr];
      ar.tlb_rd_ps   <= m_ps[ar.tlb_rd_addr];
      ar.tlb_rd_vppn <= m_vppn[ar.tlb_rd_addr];
      ar.tlb_rd_asid <= m_asid[ar.tlb_rd_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  int r_pulse, r_last_rd, r_rd_cnt, r_addr_bad, r_srch_cnt, r_rdp_cnt;
  logic r_rd_at_flush, r_ready_after, r_hit, r_e;
  logic [5:0] r_idx, r_ps;

  task automatic clear_tlb();
    for (int i = 0; i < 64; i++) begin
      m_e[i] = 1'b0; m_g[i] = 1'b0; m_ps[i] = 6'd12;
      m_vppn[i] = 19'h12345; m_asid[i] = 10'h001;
    end
  endtask

  task automatic set_entry(input int i, input logic e, input logic g, input logic [9:0] asid,
                           input logic [18:0] vppn, input logic [5:0] ps);
    m_e[i] = e; m_g[i] = g; m_asid[i] = asid; m_vppn[i] = vppn; m_ps[i] = ps;
  endtask

  // Issue one request and watch cycles T+1.. (flush_at=0: stop at the result pulse).
  task automatic run_op(input logic op, input logic [5:0] idx, input logic [18:0] vppn,
                        input logic [9:0] asid, input int max_cyc, input int flush_at);
    int w;
    w = 0;
    @(negedge clk);
    while (!rq.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!rq.req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout req_ready=%0b required=1", rq.req_ready);
    end
    rq.req_valid = 1'b1; rq.req_op = op; rq.req_idx = idx;
    csr_vppn = vppn; csr_asid = asid;
    @(posedge clk); #1;
    rq.req_valid = 1'b0; rq.req_idx = ~idx; csr_vppn = ~vppn; csr_asid = ~asid;
    r_pulse = 0; r_last_rd = 0; r_rd_cnt = 0; r_addr_bad = 0; r_srch_cnt = 0; r_rdp_cnt = 0;
    r_rd_at_flush = 1'b0; r_ready_after = 1'b0;
    for (int n = 1; n <= max_cyc; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (flush_at != 0) flush = (n == flush_at);
      #1;
      if (ar.tlb_rd_en) begin
        r_rd_cnt++; r_last_rd = n;
        if (ar.tlb_rd_addr !== (op ? idx : 6'(n - 1))) r_addr_bad++;
      end
      if (n == flush_at) r_rd_at_flush = ar.tlb_rd_en;
      if (flush_at != 0 && n == flush_at + 1) r_ready_after = rq.req_ready;
      if (TLBSRCH) r_srch_cnt++;
      if (TLBRD_en) r_rdp_cnt++;
      if ((TLBSRCH || TLBRD_en) && r_pulse == 0) begin
        r_pulse = n; r_hit = TLBSRCH_hit; r_idx = TLBSRCH_hit_idx; r_ps = TLB_PS; r_e = TLB_E;
      end
      if (flush_at == 0 && r_pulse != 0) break;
      if (flush_at != 0 && n == flush_at + 1) break;
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rq.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", rq.req_ready); end
    checks++; if (ar.tlb_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", ar.tlb_rd_en); end
    checks++; if ({TLBSRCH, TLBSRCH_hit, TLBSRCH_hit_idx, TLBRD_en, TLB_PS, TLB_E} !== 16'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {TLBSRCH, TLBSRCH_hit, TLBSRCH_hit_idx, TLBRD_en, TLB_PS, TLB_E});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_hit5();
    clear_tlb();
    set_entry(5, 1'b1, 1'b0, 10'h001, 19'h12345, 6'd12);
    run_op(1'b0, 6'd0, 19'h12345, 10'h001, 40, 0);
    checks++; if (r_pulse != 8) begin failures++; $display("FAIL hit5_pulse_cycle got=%0d exp=8", r_pulse); end
    checks++; if (r_last_rd != 7) begin failures++; $display("FAIL hit5_last_rd got=%0d exp=7", r_last_rd); end
    checks++; if (r_hit !== 1'b1 || r_idx !== 6'd5) begin failures++; $display("FAIL hit5_result got=%0b/%0d exp=1/5", r_hit, r_idx); end
    checks++; if (r_addr_bad != 0) begin failures++; $display("FAIL hit5_addr_seq got=%0d exp=0", r_addr_bad); end
    checks++; if (r_rdp_cnt != 0) begin failures++; $display("FAIL hit5_no_rd_pulse got=%0d exp=0", r_rdp_cnt); end
  endtask

  task automatic test_miss();
    clear_tlb();
    run_op(1'b0, 6'd0, 19'h12345, 10'h001, 90, 0);
    checks++; if (r_rd_cnt != 64 || r_last_rd != 64) begin failures++; $display("FAIL miss_reads got=%0d/%0d exp=64/64", r_rd_cnt, r_last_rd); end
    checks++; if (r_addr_bad != 0) begin failures++; $display("FAIL miss_addr_seq got=%0d exp=0", r_addr_bad); end
    checks++; if (r_pulse != 66) begin failures++; $display("FAIL miss_pulse_cycle got=%0d exp=66", r_pulse); end
    checks++; if (r_hit !== 1'b0 || r_idx !== 6'd5) begin failures++; $display("FAIL miss_result got=%0b/%0d exp=0/5", r_hit, r_idx); end
  endtask

  task automatic test_ps21_global();
    clear_tlb();
    set_entry(3, 1'b1, 1'b1, 10'h3FF, 19'h12200, 6'd21);
    run_op(1'b0, 6'd0, 19'h123FF, 10'h000, 40, 0);
    checks++; if (r_pulse != 6 || r_hit !== 1'b1 || r_idx !== 6'd3) begin
      failures++; $display("FAIL ps21_hit3 got=cyc%0d/%0b/%0d exp=cyc6/1/3", r_pulse, r_hit, r_idx);
    end
    set_entry(2, 1'b1, 1'b1, 10'h3FF, 19'h12200, 6'd21);
    run_op(1'b0, 6'd0, 19'h123FF, 10'h000, 40, 0);
    checks++; if (r_pulse != 5 || r_hit !== 1'b1 || r_idx !== 6'd2) begin
      failures++; $display("FAIL ps21_lowest got=cyc%0d/%0b/%0d exp=cyc5/1/2", r_pulse, r_hit, r_idx);
    end
    clear_tlb();
    set_entry(3, 1'b1, 1'b1, 10'h3FF, 19'h12200, 6'd12);
    set_entry(4, 1'b1, 1'b0, 10'h002, 19'h123FF, 6'd12);
    run_op(1'b0, 6'd0, 19'h123FF, 10'h001, 90, 0);
    checks++; if (r_pulse != 66 || r_hit !== 1'b0 || r_idx !== 6'd2) begin
      failures++; $display("FAIL ps12_asid_miss got=cyc%0d/%0b/%0d exp=cyc66/0/2", r_pulse, r_hit, r_idx);
    end
    set_entry(63, 1'b1, 1'b0, 10'h001, 19'h123FF, 6'd12);
    run_op(1'b0, 6'd0, 19'h123FF, 10'h001, 90, 0);
    checks++; if (r_pulse != 66 || r_hit !== 1'b1 || r_idx !== 6'd63) begin
      failures++; $display("FAIL hit63_last got=cyc%0d/%0b/%0d exp=cyc66/1/63", r_pulse, r_hit, r_idx);
    end
  endtask

  task automatic test_tlbrd();
    clear_tlb();
    set_entry(10, 1'b1, 1'b0, 10'h005, 19'h00ABC, 6'd21);
    run_op(1'b1, 6'd10, 19'h0, 10'h0, 20, 0);
    checks++; if (r_pulse != 3 || r_ps !== 6'd21 || r_e !== 1'b1) begin
      failures++; $display("FAIL tlbrd_e1 got=cyc%0d/ps%0d/e%0b exp=cyc3/ps21/e1", r_pulse, r_ps, r_e);
    end
    checks++; if (r_rd_cnt != 1 || r_last_rd != 1 || r_addr_bad != 0) begin
      failures++; $display("FAIL tlbrd_read got=%0d@%0d bad%0d exp=1@1 bad0", r_rd_cnt, r_last_rd, r_addr_bad);
    end
    checks++; if (r_srch_cnt != 0) begin failures++; $display("FAIL tlbrd_no_srch got=%0d exp=0", r_srch_cnt); end
    m_e[10] = 1'b0;
    run_op(1'b1, 6'd10, 19'h0, 10'h0, 20, 0);
    checks++; if (r_pulse != 3 || r_e !== 1'b0 || r_ps !== 6'd21) begin
      failures++; $display("FAIL tlbrd_e0 got=cyc%0d/ps%0d/e%0b exp=cyc3/ps21/e0", r_pulse, r_ps, r_e);
    end
  endtask

  task automatic test_flush();
    clear_tlb();
    run_op(1'b0, 6'd0, 19'h12345, 10'h001, 40, 20);
    checks++; if (r_srch_cnt != 0 || r_rdp_cnt != 0) begin
      failures++; $display("FAIL flush_no_pulse got=%0d/%0d exp=0/0", r_srch_cnt, r_rdp_cnt);
    end
    checks++; if (r_rd_at_flush !== 1'b0) begin failures++; $display("FAIL flush_rd_en got=%0b exp=0", r_rd_at_flush); end
    checks++; if (r_ready_after !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", r_ready_after); end
    checks++; if (TLBSRCH_hit !== 1'b1 || TLBSRCH_hit_idx !== 6'd63) begin
      failures++; $display("FAIL flush_data_hold got=%0b/%0d exp=1/63", TLBSRCH_hit, TLBSRCH_hit_idx);
    end
    set_entry(5, 1'b1, 1'b0, 10'h001, 19'h12345, 6'd12);
    run_op(1'b0, 6'd0, 19'h12345, 10'h001, 40, 0);
    checks++; if (r_pulse != 8 || r_hit !== 1'b1 || r_idx !== 6'd5) begin
      failures++; $display("FAIL flush_next_op got=cyc%0d/%0b/%0d exp=cyc8/1/5", r_pulse, r_hit, r_idx);
    end
  endtask

`ifdef TLB_SRCH_STATS_EN
  task automatic test_stats();
    test_reset();
    clear_tlb();
    set_entry(5, 1'b1, 1'b0, 10'h001, 19'h12345, 6'd12);
    for (int i = 0; i < 3; i++) run_op(1'b0, 6'd0, 19'h12345, 10'h001, 40, 0);
    for (int i = 0; i < 2; i++) run_op(1'b0, 6'd0, 19'h00001, 10'h001, 90, 0);
    run_op(1'b0, 6'd0, 19'h12345, 10'h001, 40, 3);
    @(posedge clk); #1;
    checks++; if (srch_hit_cnt !== 32'd3 || srch_miss_cnt !== 32'd2) begin
      failures++; $display("FAIL stats_counts got=%0d/%0d exp=3/2", srch_hit_cnt, srch_miss_cnt);
    end
  endtask
`endif

  task automatic test_reset_midop();
    clear_tlb();
    set_entry(7, 1'b1, 1'b0, 10'h001, 19'h12345, 6'd21);
    run_op(1'b1, 6'd7, 19'h0, 10'h0, 20, 0);
    run_op(1'b0, 6'd0, 19'h7FFFF, 10'h001, 10, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (rq.req_ready !== 1'b1 || ar.tlb_rd_en !== 1'b0) begin
      failures++; $display("FAIL midop_reset_ctrl got=%0b/%0b exp=1/0", rq.req_ready, ar.tlb_rd_en);
    end
    checks++; if ({TLBSRCH, TLBSRCH_hit, TLBSRCH_hit_idx, TLBRD_en, TLB_PS, TLB_E} !== 16'd0) begin
      failures++; $display("FAIL midop_reset_outputs got=%h exp=0", {TLBSRCH, TLBSRCH_hit, TLBSRCH_hit_idx, TLBRD_en, TLB_PS, TLB_E});
    end
`ifdef TLB_SRCH_STATS_EN
    checks++; if (srch_hit_cnt !== 32'd0 || srch_miss_cnt !== 32'd0) begin
      failures++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", srch_hit_cnt, srch_miss_cnt);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rq.req_valid = 1'b0; rq.req_op = 1'b0; rq.req_idx = 6'd0;
    ar.tlb_rd_e = 1'b0; ar.tlb_rd_g = 1'b0; ar.tlb_rd_ps = 6'd0;
    ar.tlb_rd_vppn = 19'd0; ar.tlb_rd_asid = 10'd0;
    clear_tlb();
    test_reset();
    test_hit5();
    test_miss();
    test_ps21_global();
    test_tlbrd();
    test_flush();
`ifdef TLB_SRCH_STATS_EN
    test_stats();
`endif
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
